imm_encoder: RTL and testbench

- Encoder side of the immediate-class instruction format consumed by the immediate control unit.
- Takes a typed request (operation, destination, source, 64-bit immediate) and emits 64-bit-variant LEGv8 I/IW/shift instruction words on a valid/ready stream into the IR load path.
- Also expands a 64-bit constant load (LDC) into one MOVZ followed by the needed MOVKs.
- Sits between the test or boot program generator and the instruction register / instruction memory writer.

---
 rtl/imm_encoder.sv | 191 +++++++++++++++++++
 tb/tb_imm_encoder.sv | 398 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_encoder.sv
// imm_encoder
// Turns a typed immediate-class request into 64-bit-variant LEGv8 I / IW /
// shift instruction words for the IR load path. A 64-bit constant load (LDC)
// becomes one MOVZ followed by the MOVKs it needs.
//
// Ports
//   clock, reset_n        rising-edge clock, asynchronous active-low reset
//   req_valid/req_ready   request handshake (req_ready high only in IDLE)
//   req_cmd               operation code (0..12 legal, 13..15 illegal)
//   req_rd, req_rn        destination / source register numbers
//   req_imm               64-bit immediate (fields are cut from it per op)
//   ir_word/ir_valid/ir_ready/ir_last   instruction word stream
//   err                   one-cycle pulse after an illegal cmd is accepted
//   busy                  high whenever the FSM is not in IDLE
//   dbg_state             current FSM state, for checkers
//
// Handshake: on both streams a beat moves on the rising edge where valid and
// ready are both high. Once ir_valid is raised, ir_word/ir_last/ir_valid stay
// put until ir_ready is seen; ir_valid never depends on ir_ready.
module imm_encoder #(
    parameter bit NONE_SKIP = 1'b1  // 1: LDC skips MOVKs for zero halfwords
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_cmd,
    input  logic [4:0]  req_rd,
    input  logic [4:0]  req_rn,
    input  logic [63:0] req_imm,
    output logic [31:0] ir_word,
    output logic        ir_valid,
    input  logic        ir_ready,
    output logic        ir_last,
    output logic        err,
    output logic        busy,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        EMIT_ONE  = 3'd1,
        EMIT_MOVZ = 3'd2,
        EMIT_MOVK = 3'd3,
        ERR       = 3'd4
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [3:0]  cmd_q;
    logic [4:0]  rd_q;
    logic [4:0]  rn_q;
    logic [63:0] imm_q;
    logic [2:0]  mask_q;     // bit k: MOVK with hw=k+1 still to be emitted
    logic [2:0]  mask_init;
    logic        accept;
    logic        one_left;
    logic [1:0]  movk_hw;
    logic [15:0] movk_imm;
    logic [31:0] single_word;
    logic [31:0] math_fields;
    logic [31:0] shift_fields;

    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign dbg_state = state;
    assign accept    = req_valid & req_ready;

    assign mask_init = NONE_SKIP ? {|req_imm[63:48], |req_imm[47:32], |req_imm[31:16]}
                                 : 3'b111;

    // Clearing the lowest set bit leaves zero exactly when one bit was set.
    assign one_left = ((mask_q & (mask_q - 3'd1)) == 3'd0);

    // Lowest pending halfword first, so MOVKs come out in ascending hw order.
    always_comb begin
        movk_hw  = 2'd3;
        movk_imm = imm_q[63:48];
        if (mask_q[0]) begin
            movk_hw  = 2'd1;
            movk_imm = imm_q[31:16];
        end else if (mask_q[1]) begin
            movk_hw  = 2'd2;
            movk_imm = imm_q[47:32];
        end
    end

    assign math_fields  = {10'b0, imm_q[11:0], rn_q, rd_q};
    assign shift_fields = {16'b0, imm_q[5:0], rn_q, rd_q};

    always_comb begin
        single_word = 32'h0;
        case (cmd_q)
            4'd0:    single_word = 32'h9100_0000 | math_fields;
            4'd1:    single_word = 32'hB100_0000 | math_fields;
            4'd2:    single_word = 32'hD100_0000 | math_fields;
            4'd3:    single_word = 32'hF100_0000 | math_fields;
            4'd4:    single_word = 32'h9200_0000 | math_fields;
            4'd5:    single_word = 32'hB200_0000 | math_fields;
            4'd6:    single_word = 32'hD200_0000 | math_fields;
            4'd7:    single_word = 32'hF200_0000 | math_fields;
            4'd8:    single_word = 32'hD360_0000 | shift_fields;
            4'd9:    single_word = 32'hD340_0000 | shift_fields;
            4'd10:   single_word = 32'hD280_0000 | {9'b0, imm_q[17:0], rd_q};
            4'd11:   single_word = 32'hF280_0000 | {9'b0, imm_q[17:0], rd_q};
            default: single_word = 32'h0;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Request fields are captured once; the requester may change them freely
    // after acceptance.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cmd_q  <= 4'd0;
            rd_q   <= 5'd0;
            rn_q   <= 5'd0;
            imm_q  <= 64'd0;
            mask_q <= 3'd0;
        end else if (accept) begin
            cmd_q  <= req_cmd;
            rd_q   <= req_rd;
            rn_q   <= req_rn;
            imm_q  <= req_imm;
            mask_q <= mask_init;
        end else if (state == EMIT_MOVK && ir_ready) begin
            mask_q <= mask_q & (mask_q - 3'd1);
        end
    end

    always_comb begin
        state_next = state;
        ir_valid   = 1'b0;
        ir_word    = 32'h0;
        ir_last    = 1'b0;
        err        = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (req_cmd <= 4'd11) begin
                        state_next = EMIT_ONE;
                    end else if (req_cmd == 4'd12) begin
                        state_next = EMIT_MOVZ;
                    end else begin
                        state_next = ERR;
                    end
                end
            end
            EMIT_ONE: begin
                ir_valid = 1'b1;
                ir_word  = single_word;
                ir_last  = 1'b1;
                if (ir_ready) begin
                    state_next = IDLE;
                end
            end
            EMIT_MOVZ: begin
                ir_valid = 1'b1;
                ir_word  = 32'hD280_0000 | {9'b0, 2'b00, imm_q[15:0], rd_q};
                ir_last  = (mask_q == 3'd0);
                if (ir_ready) begin
                    state_next = (mask_q == 3'd0) ? IDLE : EMIT_MOVK;
                end
            end
            EMIT_MOVK: begin
                ir_valid = 1'b1;
                ir_word  = 32'hF280_0000 | {9'b0, movk_hw, movk_imm, rd_q};
                ir_last  = one_left;
                if (ir_ready && one_left) begin
                    state_next = IDLE;
                end
            end
            ERR: begin
                err        = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_imm_encoder.sv
// Bench for imm_encoder. Two instances share every input: u=0 has
// NONE_SKIP=1, u=1 has NONE_SKIP=0. Expected words come from a model that
// builds each instruction from its field layout with plain arithmetic.
module tb_imm_encoder;

    logic        clock;
    logic        reset_n;
    logic        req_valid;
    logic [3:0]  req_cmd;
    logic [4:0]  req_rd;
    logic [4:0]  req_rn;
    logic [63:0] req_imm;
    logic        ir_ready_man;
    logic        rnd_en;
    logic        rnd_bit;
    logic        ir_ready;

    logic        req_ready [2];
    logic [31:0] ir_word   [2];
    logic        ir_valid  [2];
    logic        ir_last   [2];
    logic        err       [2];
    logic        busy      [2];
    logic [2:0]  dbg_state [2];

    logic [32:0] exp_q [2][$];
    logic [32:0] got_q [2][$];

    int          vectors;
    int          miscompares;
    logic [2:0]  idle_code;

    assign ir_ready = rnd_en ? rnd_bit : ir_ready_man;

    imm_encoder #(.NONE_SKIP(1'b1)) u_skip (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready[0]),
        .req_cmd(req_cmd), .req_rd(req_rd), .req_rn(req_rn), .req_imm(req_imm),
        .ir_word(ir_word[0]), .ir_valid(ir_valid[0]), .ir_ready(ir_ready),
        .ir_last(ir_last[0]), .err(err[0]), .busy(busy[0]), .dbg_state(dbg_state[0])
    );

    imm_encoder #(.NONE_SKIP(1'b0)) u_full (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready[1]),
        .req_cmd(req_cmd), .req_rd(req_rd), .req_rn(req_rn), .req_imm(req_imm),
        .ir_word(ir_word[1]), .ir_valid(ir_valid[1]), .ir_ready(ir_ready),
        .ir_last(ir_last[1]), .err(err[1]), .busy(busy[1]), .dbg_state(dbg_state[1])
    );

    // ---------------- clock / reset ----------------
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Random backpressure, changed just after each rising edge.
    always @(posedge clock) begin
        #1;
        rnd_bit = ($urandom_range(0, 3) != 0);
    end

    // Every word that transfers on the next rising edge is recorded.
    always @(negedge clock) begin
        for (int u = 0; u < 2; u++) begin
            if (reset_n && ir_valid[u] && ir_ready) begin
                got_q[u].push_back({ir_last[u], ir_word[u]});
            end
        end
    end

    // ---------------- reference model ----------------
    function automatic logic [31:0] mov_word(input bit keep, input logic [63:0] hw,
                                             input logic [63:0] imm16, input logic [63:0] rd);
        logic [63:0] w;
        w = (keep ? 64'hF280_0000 : 64'hD280_0000) + hw * 2097152 + imm16 * 32 + rd;
        return w[31:0];
    endfunction

    function automatic logic [31:0] enc_single(input logic [63:0] cmd, input logic [63:0] rd,
                                               input logic [63:0] rn, input logic [63:0] imm);
        logic [63:0] w;
        w = 64'd0;
        case (cmd)
            0: w = 64'h9100_0000;
            1: w = 64'hB100_0000;
            2: w = 64'hD100_0000;
            3: w = 64'hF100_0000;
            4: w = 64'h9200_0000;
            5: w = 64'hB200_0000;
            6: w = 64'hD200_0000;
            7: w = 64'hF200_0000;
            8: w = 64'hD360_0000;
            9: w = 64'hD340_0000;
            default: w = 64'd0;
        endcase
        if (cmd <= 7) begin
            w = w + (imm % 4096) * 1024 + rn * 32 + rd;
        end else if (cmd <= 9) begin
            w = w + (imm % 64) * 1024 + rn * 32 + rd;
        end else begin
            return mov_word(cmd == 11, (imm / 65536) % 4, imm % 65536, rd);
        end
        return w[31:0];
    endfunction

    task automatic fill_exp(input logic [3:0] cmd, input logic [4:0] rd, input logic [4:0] rn,
                            input logic [63:0] imm);
        logic [63:0] hv;
        logic [32:0] tail;
        for (int u = 0; u < 2; u++) begin
            exp_q[u].delete();
            if (cmd <= 4'd11) begin
                exp_q[u].push_back({1'b1, enc_single(64'(cmd), 64'(rd), 64'(rn), imm)});
            end else if (cmd == 4'd12) begin
                exp_q[u].push_back({1'b0, mov_word(1'b0, 64'd0, imm % 65536, 64'(rd))});
                for (int h = 1; h <= 3; h++) begin
                    hv = (imm >> (16 * h)) % 65536;
                    if (u == 1 || hv != 0) begin
                        exp_q[u].push_back({1'b0, mov_word(1'b1, 64'(h), hv, 64'(rd))});
                    end
                end
                tail = exp_q[u].pop_back();
                tail[32] = 1'b1;
                exp_q[u].push_back(tail);
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    // Accept happens on the second rising edge; fields are scrambled afterwards.
    task automatic start_txn(input logic [3:0] cmd, input logic [4:0] rd, input logic [4:0] rn,
                             input logic [63:0] imm);
        for (int u = 0; u < 2; u++) got_q[u].delete();
        fill_exp(cmd, rd, rn, imm);
        @(posedge clock); #1;
        req_valid = 1'b1;
        req_cmd   = cmd;
        req_rd    = rd;
        req_rn    = rn;
        req_imm   = imm;
        @(posedge clock); #1;
        req_valid = 1'b0;
        req_cmd   = 4'($urandom_range(0, 15));
        req_rd    = 5'($urandom_range(0, 31));
        req_rn    = 5'($urandom_range(0, 31));
        req_imm   = {$urandom, $urandom};
    endtask

    task automatic finish_txn(output bit timed_out);
        timed_out = 1'b1;
        for (int c = 0; c < 300; c++) begin
            @(negedge clock);
            if (!busy[0] && !busy[1]) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        idle_code = dbg_state[0];
        for (int u = 0; u < 2; u++) begin
            vectors += 6;
            if (req_ready[u] !== 1'b1) begin miscompares++; $display("FAIL reset_req_ready u%0d got %b exp 1", u, req_ready[u]); end
            if (ir_valid[u] !== 1'b0) begin miscompares++; $display("FAIL reset_ir_valid u%0d got %b exp 0", u, ir_valid[u]); end
            if (ir_word[u] !== 32'h0) begin miscompares++; $display("FAIL reset_ir_word u%0d got %h exp 0", u, ir_word[u]); end
            if (ir_last[u] !== 1'b0) begin miscompares++; $display("FAIL reset_ir_last u%0d got %b exp 0", u, ir_last[u]); end
            if (err[u] !== 1'b0) begin miscompares++; $display("FAIL reset_err u%0d got %b exp 0", u, err[u]); end
            if (busy[u] !== 1'b0) begin miscompares++; $display("FAIL reset_busy u%0d got %b exp 0", u, busy[u]); end
        end
    endtask

    task automatic test_addi();
        bit to;
        ir_ready_man = 1'b1;
        start_txn(4'd0, 5'd3, 5'd4, 64'd5);
        @(negedge clock);
        for (int u = 0; u < 2; u++) begin
            vectors += 2;
            if (ir_valid[u] !== 1'b1) begin miscompares++; $display("FAIL addi_latency u%0d ir_valid got %b exp 1", u, ir_valid[u]); end
            if (ir_word[u] !== 32'h9100_1483) begin miscompares++; $display("FAIL addi_word u%0d got %h exp 91001483", u, ir_word[u]); end
        end
        finish_txn(to);
        vectors++;
        if (to) begin miscompares++; $display("FAIL addi_timeout got busy exp idle"); end
        for (int u = 0; u < 2; u++) begin
            vectors++;
            if (got_q[u].size() != exp_q[u].size()) begin
                miscompares++; $display("FAIL addi_count u%0d got %0d exp %0d", u, got_q[u].size(), exp_q[u].size());
            end else begin
                for (int k = 0; k < exp_q[u].size(); k++) begin
                    vectors++;
                    if (got_q[u][k] !== exp_q[u][k]) begin miscompares++; $display("FAIL addi_word%0d u%0d got %h exp %h", k, u, got_q[u][k], exp_q[u][k]); end
                end
            end
        end
    endtask

    // Table of fixed cases: shifts, spec LDC, zero LDC, truncated fields.
    task automatic test_table();
        bit to;
        logic [3:0]  t_cmd [7] = '{4'd8, 4'd9, 4'd12, 4'd12, 4'd3, 4'd11, 4'd7};
        logic [4:0]  t_rd  [7] = '{5'd1, 5'd1, 5'd9, 5'd0, 5'd31, 5'd17, 5'd5};
        logic [4:0]  t_rn  [7] = '{5'd2, 5'd2, 5'd0, 5'd0, 5'd30, 5'd0, 5'd6};
        logic [63:0] t_imm [7] = '{64'd4, 64'd4, 64'h0000_1234_0000_5678, 64'd0,
                                   64'hFFFF_FFFF_FFFF_FFFF, 64'h0007_ABCD, 64'h0000_0000_0000_0FFF};
        ir_ready_man = 1'b1;
        for (int t = 0; t < 7; t++) begin
            start_txn(t_cmd[t], t_rd[t], t_rn[t], t_imm[t]);
            finish_txn(to);
            vectors++;
            if (to) begin miscompares++; $display("FAIL table%0d_timeout got busy exp idle", t); end
            for (int u = 0; u < 2; u++) begin
                vectors++;
                if (got_q[u].size() != exp_q[u].size()) begin
                    miscompares++; $display("FAIL table%0d_count u%0d got %0d exp %0d", t, u, got_q[u].size(), exp_q[u].size());
                end else begin
                    for (int k = 0; k < exp_q[u].size(); k++) begin
                        vectors++;
                        if (got_q[u][k] !== exp_q[u][k]) begin miscompares++; $display("FAIL table%0d_word%0d u%0d got %h exp %h", t, k, u, got_q[u][k], exp_q[u][k]); end
                    end
                end
            end
        end
        // Anchor the model against the hand-encoded words for the spec LDC.
        fill_exp(4'd12, 5'd9, 5'd0, 64'h0000_1234_0000_5678);
        vectors += 2;
        if (exp_q[0].size() != 2 || exp_q[0][0] !== {1'b0, 32'hD28A_CF09} || exp_q[0][1] !== {1'b1, 32'hF2C2_4689}) begin
            miscompares++; $display("FAIL model_ldc_skip got %0d words exp D28ACF09,F2C24689", exp_q[0].size());
        end
        if (exp_q[1].size() != 4) begin miscompares++; $display("FAIL model_ldc_full got %0d words exp 4", exp_q[1].size()); end
    endtask

    task automatic test_backpressure();
        bit to;
        ir_ready_man = 1'b1;
        start_txn(4'd12, 5'd12, 5'd0, 64'h1111_2222_3333_4444);
        @(negedge clock);
        @(posedge clock); #1;
        ir_ready_man = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            for (int u = 0; u < 2; u++) begin
                vectors += 4;
                if (ir_valid[u] !== 1'b1) begin miscompares++; $display("FAIL bp_valid c%0d u%0d got %b exp 1", i, u, ir_valid[u]); end
                if (ir_word[u] !== exp_q[u][1][31:0]) begin miscompares++; $display("FAIL bp_word c%0d u%0d got %h exp %h", i, u, ir_word[u], exp_q[u][1][31:0]); end
                if (ir_last[u] !== exp_q[u][1][32]) begin miscompares++; $display("FAIL bp_last c%0d u%0d got %b exp %b", i, u, ir_last[u], exp_q[u][1][32]); end
                if (req_ready[u] !== 1'b0) begin miscompares++; $display("FAIL bp_req_ready c%0d u%0d got %b exp 0", i, u, req_ready[u]); end
            end
        end
        @(posedge clock); #1;
        ir_ready_man = 1'b1;
        finish_txn(to);
        vectors++;
        if (to) begin miscompares++; $display("FAIL bp_timeout got busy exp idle"); end
        for (int u = 0; u < 2; u++) begin
            vectors++;
            if (got_q[u].size() != exp_q[u].size()) begin
                miscompares++; $display("FAIL bp_count u%0d got %0d exp %0d", u, got_q[u].size(), exp_q[u].size());
            end else begin
                for (int k = 0; k < exp_q[u].size(); k++) begin
                    vectors++;
                    if (got_q[u][k] !== exp_q[u][k]) begin miscompares++; $display("FAIL bp_word%0d u%0d got %h exp %h", k, u, got_q[u][k], exp_q[u][k]); end
                end
            end
        end
    endtask

    task automatic test_err();
        ir_ready_man = 1'b1;
        start_txn(4'd14, 5'd1, 5'd1, 64'd1);
        @(negedge clock);
        for (int u = 0; u < 2; u++) begin
            vectors += 2;
            if (err[u] !== 1'b1) begin miscompares++; $display("FAIL err_pulse u%0d got %b exp 1", u, err[u]); end
            if (ir_valid[u] !== 1'b0) begin miscompares++; $display("FAIL err_no_word u%0d got %b exp 0", u, ir_valid[u]); end
        end
        @(negedge clock);
        for (int u = 0; u < 2; u++) begin
            vectors += 4;
            if (err[u] !== 1'b0) begin miscompares++; $display("FAIL err_one_cycle u%0d got %b exp 0", u, err[u]); end
            if (req_ready[u] !== 1'b1) begin miscompares++; $display("FAIL err_idle u%0d req_ready got %b exp 1", u, req_ready[u]); end
            if (dbg_state[u] !== idle_code) begin miscompares++; $display("FAIL err_state u%0d got %0d exp %0d", u, dbg_state[u], idle_code); end
            if (got_q[u].size() != 0) begin miscompares++; $display("FAIL err_words u%0d got %0d exp 0", u, got_q[u].size()); end
        end
    endtask

    task automatic test_reset_mid();
        bit to;
        ir_ready_man = 1'b1;
        start_txn(4'd12, 5'd9, 5'd0, 64'h0000_1234_0000_5678);
        @(negedge clock);
        @(posedge clock); #1;
        ir_ready_man = 1'b0;
        @(negedge clock);
        for (int u = 0; u < 2; u++) begin
            vectors++;
            if (ir_valid[u] !== 1'b1) begin miscompares++; $display("FAIL rmid_second_word u%0d got %b exp 1", u, ir_valid[u]); end
        end
        #2 reset_n = 1'b0;
        #1;
        for (int u = 0; u < 2; u++) begin
            vectors += 5;
            if (ir_valid[u] !== 1'b0) begin miscompares++; $display("FAIL rmid_valid u%0d got %b exp 0", u, ir_valid[u]); end
            if (ir_word[u] !== 32'h0) begin miscompares++; $display("FAIL rmid_word u%0d got %h exp 0", u, ir_word[u]); end
            if (ir_last[u] !== 1'b0) begin miscompares++; $display("FAIL rmid_last u%0d got %b exp 0", u, ir_last[u]); end
            if (busy[u] !== 1'b0) begin miscompares++; $display("FAIL rmid_busy u%0d got %b exp 0", u, busy[u]); end
            if (req_ready[u] !== 1'b1) begin miscompares++; $display("FAIL rmid_req_ready u%0d got %b exp 1", u, req_ready[u]); end
        end
        repeat (2) @(negedge clock);
        for (int u = 0; u < 2; u++) got_q[u].delete();
        ir_ready_man = 1'b1;
        reset_n = 1'b1;
        repeat (3) @(negedge clock);
        for (int u = 0; u < 2; u++) begin
            vectors += 2;
            if (got_q[u].size() != 0) begin miscompares++; $display("FAIL rmid_partial u%0d got %0d words exp 0", u, got_q[u].size()); end
            if (req_ready[u] !== 1'b1) begin miscompares++; $display("FAIL rmid_after u%0d req_ready got %b exp 1", u, req_ready[u]); end
        end
        start_txn(4'd3, 5'd7, 5'd8, 64'h00FF_FFFF);
        finish_txn(to);
        vectors++;
        if (to) begin miscompares++; $display("FAIL rmid_timeout got busy exp idle"); end
        for (int u = 0; u < 2; u++) begin
            vectors++;
            if (got_q[u].size() != exp_q[u].size()) begin
                miscompares++; $display("FAIL rmid_count u%0d got %0d exp %0d", u, got_q[u].size(), exp_q[u].size());
            end else begin
                for (int k = 0; k < exp_q[u].size(); k++) begin
                    vectors++;
                    if (got_q[u][k] !== exp_q[u][k]) begin miscompares++; $display("FAIL rmid_word%0d u%0d got %h exp %h", k, u, got_q[u][k], exp_q[u][k]); end
                end
            end
        end
    endtask

    task automatic test_random();
        bit          to;
        logic [3:0]  cmd;
        logic [63:0] imm;
        rnd_en = 1'b1;
        for (int t = 0; t < 60; t++) begin
            cmd = ($urandom_range(0, 3) == 0) ? 4'd12 : 4'($urandom_range(0, 15));
            imm = {$urandom, $urandom};
            for (int h = 0; h < 4; h++) begin
                if ($urandom_range(0, 1) == 1) imm[16*h +: 16] = 16'h0;
            end
            start_txn(cmd, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), imm);
            finish_txn(to);
            vectors++;
            if (to) begin miscompares++; $display("FAIL rnd%0d_timeout got busy exp idle", t); end
            for (int u = 0; u < 2; u++) begin
                vectors++;
                if (got_q[u].size() != exp_q[u].size()) begin
                    miscompares++; $display("FAIL rnd%0d_count cmd=%0d u%0d got %0d exp %0d", t, cmd, u, got_q[u].size(), exp_q[u].size());
                end else begin
                    for (int k = 0; k < exp_q[u].size(); k++) begin
                        vectors++;
                        if (got_q[u][k] !== exp_q[u][k]) begin miscompares++; $display("FAIL rnd%0d_word%0d cmd=%0d u%0d got %h exp %h", t, k, cmd, u, got_q[u][k], exp_q[u][k]); end
                    end
                end
            end
        end
        rnd_en = 1'b0;
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        vectors      = 0;
        miscompares  = 0;
        reset_n      = 1'b0;
        req_valid    = 1'b0;
        req_cmd      = 4'd0;
        req_rd       = 5'd0;
        req_rn       = 5'd0;
        req_imm      = 64'd0;
        ir_ready_man = 1'b1;
        rnd_en       = 1'b0;
        rnd_bit      = 1'b1;
        test_reset();
        test_addi();
        test_table();
        test_backpressure();
        test_err();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
